drive_mode_arbiter: RTL and testbench



---
 rtl/drive_pkg.sv | 30 +++
 rtl/drive_mode_arbiter_tick_gen.sv | 29 ++
 rtl/drive_mode_arbiter.sv | 141 ++++++++++++++
 tb/tb_drive_mode_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared chassis command codes and arbiter state encoding, used by the arbiter
// and by both driving controllers.
package drive_pkg;

  localparam logic [1:0] MOVE = 2'b10;
  localparam logic [1:0] TURN = 2'b01;
  localparam logic [1:0] WAIT = 2'b00;

  localparam logic [3:0] FRONT = 4'b0001;
  localparam logic [3:0] BACK  = 4'b0010;
  localparam logic [3:0] RIGHT = 4'b0100;
  localparam logic [3:0] LEFT  = 4'b1000;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    IDLE   = 3'd1,
    MANUAL = 3'd2,
    AUTO   = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } arb_state_t;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] mv;
  } motion_t;

  localparam motion_t SAFE_CMD = '{st: WAIT, mv: FRONT};

endpackage

// File: rtl/drive_mode_arbiter_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV cycles; held at zero
// while disabled so the tick phase restarts on every power-up.
module tick_gen #(
  parameter int TICK_DIV = 2000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_presc;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_presc <= '0;
    end else if (r_presc == LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign o_tick = i_en && (r_presc == LAST);

endmodule

// File: rtl/drive_mode_arbiter.sv
// Arbitrates the chassis command bus and beacon actuator between the manual
// and autonomous controllers, with power sequencing and a stop dwell on switch.
module drive_mode_arbiter
  import drive_pkg::*;
#(
  parameter int TICK_DIV         = 2000000,
  parameter int SWITCH_TICKS     = 25,
  parameter int BEACON_GAP_TICKS = 10,
  parameter int MAX_BEACONS      = 15
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       power,
  input  logic       mode_sel,
  input  logic [1:0] man_state,
  input  logic [3:0] man_move,
  input  logic [1:0] auto_state,
  input  logic [3:0] auto_move,
  input  logic       auto_pl_beacon,
  input  logic       auto_de_beacon,
  output logic [1:0] next_state,
  output logic [3:0] next_moving_state,
  output logic       auto_en,
  output logic       place_pulse,
  output logic [3:0] beacon_cnt,
  output logic       done,
  output logic       mode_busy
);

  localparam int DW_RAW = $clog2(SWITCH_TICKS + 1);
  localparam int GW_RAW = $clog2(BEACON_GAP_TICKS + 1);
  localparam int DW     = (DW_RAW < 1) ? 1 : DW_RAW;
  localparam int GW     = (GW_RAW < 1) ? 1 : GW_RAW;

  arb_state_t    r_state, w_nxt;
  motion_t       r_cmd, w_cmd;
  logic          r_auto_en, r_place, r_done, r_busy;
  logic [3:0]    r_beacon_cnt;
  logic [DW-1:0] r_drain_cnt;
  logic [GW-1:0] r_gap;
  logic          r_pl_d, r_de_d;
  logic          w_tick, w_tick_en, w_pl_edge, w_de_edge, w_accept, w_auto_entry;

  assign w_tick_en = (r_state != OFF);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .i_clk  (sys_clk),
    .i_rst  (rst),
    .i_en   (w_tick_en),
    .o_tick (w_tick)
  );

  assign w_pl_edge    = auto_pl_beacon & ~r_pl_d;
  assign w_de_edge    = auto_de_beacon & ~r_de_d;
  assign w_accept     = (r_state == AUTO) && w_pl_edge &&
                        (r_beacon_cnt < 4'(MAX_BEACONS)) && (r_gap == '0);
  assign w_auto_entry = (r_state != AUTO) && (w_nxt == AUTO);

  // Next state and the command that goes with it; outputs are registered
  // against the state being entered so they change together with it.
  always_comb begin
    w_nxt = r_state;
    if (!power) begin
      w_nxt = OFF;
    end else begin
      case (r_state)
        OFF:     w_nxt = IDLE;
        IDLE:    w_nxt = mode_sel ? AUTO : MANUAL;
        MANUAL:  if (mode_sel) w_nxt = DRAIN;
        AUTO: begin
          if (w_de_edge)      w_nxt = DONE;
          else if (!mode_sel) w_nxt = DRAIN;
        end
        DRAIN: begin
          if (w_tick && (r_drain_cnt == DW'(SWITCH_TICKS - 1)))
            w_nxt = mode_sel ? AUTO : MANUAL;
        end
        DONE:    if (!mode_sel) w_nxt = DRAIN;
        default: w_nxt = OFF;
      endcase
    end

    w_cmd = SAFE_CMD;
    if (w_nxt == MANUAL) begin
      w_cmd = '{st: man_state, mv: man_move};
    end else if (w_nxt == AUTO) begin
      w_cmd = '{st: auto_state, mv: auto_move};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state      <= OFF;
      r_cmd        <= SAFE_CMD;
      r_auto_en    <= 1'b0;
      r_place      <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_beacon_cnt <= '0;
      r_drain_cnt  <= '0;
      r_gap        <= '0;
      r_pl_d       <= 1'b0;
      r_de_d       <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cmd     <= w_cmd;
      r_auto_en <= (w_nxt == AUTO);
      r_done    <= (w_nxt == DONE);
      r_busy    <= (w_nxt == DRAIN);
      r_place   <= w_accept;
      r_pl_d    <= auto_pl_beacon;
      r_de_d    <= auto_de_beacon;

      // Counter sits at zero outside DRAIN, so every entry starts a full dwell.
      if (r_state != DRAIN) begin
        r_drain_cnt <= '0;
      end else if (w_tick) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end

      if (w_auto_entry) begin
        r_beacon_cnt <= '0;
        r_gap        <= '0;
      end else if (w_accept) begin
        r_beacon_cnt <= r_beacon_cnt + 1'b1;
        r_gap        <= GW'(BEACON_GAP_TICKS);
      end else if (w_tick && (r_gap != '0)) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  end

  assign next_state        = r_cmd.st;
  assign next_moving_state = r_cmd.mv;
  assign auto_en           = r_auto_en;
  assign place_pulse       = r_place;
  assign beacon_cnt        = r_beacon_cnt;
  assign done              = r_done;
  assign mode_busy         = r_busy;

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Bench for drive_mode_arbiter: vector table, hand-written corner sequences
// and a randomized run against a behavioural model.
module tb_drive_mode_arbiter;
  import drive_pkg::*;

  localparam int TB_TICK = 4;
  localparam int TB_SW   = 3;
  localparam int TB_GAP  = 2;
  localparam int TB_MAX  = 3;

  localparam int M_OFF = 0, M_IDLE = 1, M_MAN = 2, M_AUTO = 3, M_DRAIN = 4, M_DONE = 5;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1, power = 1'b0, mode_sel = 1'b0;
  logic [1:0] man_state = WAIT, auto_state = WAIT;
  logic [3:0] man_move = FRONT, auto_move = FRONT;
  logic       auto_pl_beacon = 1'b0, auto_de_beacon = 1'b0;
  logic [1:0] next_state;
  logic [3:0] next_moving_state;
  logic       auto_en, place_pulse, done, mode_busy;
  logic [3:0] beacon_cnt;

  always #5 sys_clk = ~sys_clk;

  drive_mode_arbiter #(
    .TICK_DIV(TB_TICK), .SWITCH_TICKS(TB_SW),
    .BEACON_GAP_TICKS(TB_GAP), .MAX_BEACONS(TB_MAX)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .power(power), .mode_sel(mode_sel),
    .man_state(man_state), .man_move(man_move),
    .auto_state(auto_state), .auto_move(auto_move),
    .auto_pl_beacon(auto_pl_beacon), .auto_de_beacon(auto_de_beacon),
    .next_state(next_state), .next_moving_state(next_moving_state),
    .auto_en(auto_en), .place_pulse(place_pulse), .beacon_cnt(beacon_cnt),
    .done(done), .mode_busy(mode_busy)
  );

  logic [13:0] w_obs;
  assign w_obs = {next_state, next_moving_state, auto_en, place_pulse, beacon_cnt, done, mode_busy};

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  function automatic logic [13:0] pk(logic [1:0] s, logic [3:0] m, logic a, logic p,
                                     logic [3:0] c, logic d, logic b);
    return {s, m, a, p, c, d, b};
  endfunction

  task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    n_pulses += int'(place_pulse);
  endtask

  task automatic wait_sig(input bit use_aen, input logic want, input string nm);
    logic v;
    for (int i = 0; i < 40; i++) begin
      v = use_aen ? auto_en : mode_busy;
      if (v === want) break;
      step();
    end
    v = use_aen ? auto_en : mode_busy;
    chk(nm, 14'(v), 14'(want));
  endtask

  // Behavioural reference: mode as a small integer, tick phase as cycles
  // since power-up modulo the divider, dwell and gap as tick countdowns.
  int          m_mode = M_OFF, m_phase = 0, m_dticks = 0, m_gap = 0, m_cnt = 0;
  bit          m_pl_prev = 0, m_de_prev = 0;
  logic [13:0] m_exp = '0;

  function automatic void model_step();
    int nm;
    bit tick, ple, dee, acc;
    if (rst) begin
      m_mode = M_OFF; m_phase = 0; m_dticks = 0; m_gap = 0; m_cnt = 0;
      m_pl_prev = 0; m_de_prev = 0;
      m_exp = pk(WAIT, FRONT, 0, 0, 0, 0, 0);
      return;
    end
    tick = (m_mode != M_OFF) && (m_phase == TB_TICK - 1);
    ple  = auto_pl_beacon && !m_pl_prev;
    dee  = auto_de_beacon && !m_de_prev;
    acc  = (m_mode == M_AUTO) && ple && (m_cnt < TB_MAX) && (m_gap == 0);
    nm = m_mode;
    if (!power) nm = M_OFF;
    else if (m_mode == M_OFF) nm = M_IDLE;
    else if (m_mode == M_IDLE) nm = mode_sel ? M_AUTO : M_MAN;
    else if (m_mode == M_MAN && mode_sel) nm = M_DRAIN;
    else if (m_mode == M_AUTO && dee) nm = M_DONE;
    else if (m_mode == M_AUTO && !mode_sel) nm = M_DRAIN;
    else if (m_mode == M_DRAIN && tick && (m_dticks + 1 == TB_SW)) nm = mode_sel ? M_AUTO : M_MAN;
    else if (m_mode == M_DONE && !mode_sel) nm = M_DRAIN;

    m_phase = (m_mode == M_OFF) ? 0 : (m_phase + 1) % TB_TICK;
    m_dticks = (m_mode == M_DRAIN) ? m_dticks + int'(tick) : 0;
    if (nm == M_AUTO && m_mode != M_AUTO) begin
      m_cnt = 0; m_gap = 0;
    end else if (acc) begin
      m_cnt++; m_gap = TB_GAP;
    end else if (tick && m_gap > 0) begin
      m_gap--;
    end

    if (nm == M_MAN)
      m_exp = pk(man_state, man_move, 0, acc, 4'(m_cnt), 0, 0);
    else if (nm == M_AUTO)
      m_exp = pk(auto_state, auto_move, 1, acc, 4'(m_cnt), 0, 0);
    else
      m_exp = pk(WAIT, FRONT, 0, acc, 4'(m_cnt), nm == M_DONE, nm == M_DRAIN);
    m_pl_prev = auto_pl_beacon;
    m_de_prev = auto_de_beacon;
    m_mode = nm;
  endfunction

  typedef struct {
    logic        r, p, ms;
    logic [1:0]  mst;
    logic [3:0]  mmv;
    logic [1:0]  ast;
    logic [3:0]  amv;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic r, logic p, logic ms, logic [1:0] mst, logic [3:0] mmv,
                               logic [1:0] ast, logic [3:0] amv, logic [13:0] exp);
    vec_t v;
    v.r = r; v.p = p; v.ms = ms; v.mst = mst; v.mmv = mmv;
    v.ast = ast; v.amv = amv; v.exp = exp;
    return v;
  endfunction

  initial begin
    logic [13:0] safe0, busy0;
    safe0 = pk(WAIT, FRONT, 0, 0, 0, 0, 0);
    busy0 = pk(WAIT, FRONT, 0, 0, 0, 0, 1);

    // Power-up into MANUAL, then a tick-aligned switch to AUTO (12-cycle dwell).
    tbl.push_back(mkv(1, 0, 0, MOVE, LEFT, MOVE, FRONT, safe0));
    tbl.push_back(mkv(1, 0, 0, MOVE, LEFT, MOVE, FRONT, safe0));
    tbl.push_back(mkv(0, 1, 0, MOVE, LEFT, MOVE, FRONT, safe0));
    tbl.push_back(mkv(0, 1, 0, MOVE, LEFT, MOVE, FRONT, pk(MOVE, LEFT, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv(0, 1, 0, TURN, RIGHT, MOVE, FRONT, pk(TURN, RIGHT, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv(0, 1, 0, TURN, RIGHT, MOVE, FRONT, pk(TURN, RIGHT, 0, 0, 0, 0, 0)));
    for (int k = 6; k <= 17; k++)
      tbl.push_back(mkv(0, 1, (k == 9 || k == 10) ? 1'b0 : 1'b1, TURN, RIGHT, MOVE, FRONT, busy0));
    tbl.push_back(mkv(0, 1, 1, TURN, RIGHT, MOVE, FRONT, pk(MOVE, FRONT, 1, 0, 0, 0, 0)));
    tbl.push_back(mkv(0, 1, 1, TURN, RIGHT, TURN, LEFT, pk(TURN, LEFT, 1, 0, 0, 0, 0)));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; power = tbl[i].p; mode_sel = tbl[i].ms;
      man_state = tbl[i].mst; man_move = tbl[i].mmv;
      auto_state = tbl[i].ast; auto_move = tbl[i].amv;
      step();
      chk($sformatf("vec%0d", i), w_obs, tbl[i].exp);
    end

    // Gap rule: second edge 3 cycles later is dropped; one 9 cycles later is taken.
    n_pulses = 0;
    auto_pl_beacon = 1; step();
    chk("place_first", 14'(place_pulse), 14'(1));
    auto_pl_beacon = 0; step(); step();
    auto_pl_beacon = 1; step();
    chk("gap_reject", 14'(place_pulse), 14'(0));
    auto_pl_beacon = 0; repeat (8) step();
    chk("gap_pulses", 14'(n_pulses), 14'(1));
    chk("gap_cnt1", 14'(beacon_cnt), 14'(1));
    auto_pl_beacon = 1; step(); auto_pl_beacon = 0; step();
    chk("gap_cnt2", 14'(beacon_cnt), 14'(2));

    // Leave AUTO through DRAIN to MANUAL, then back: the new run clears the count.
    man_state = MOVE; man_move = BACK;
    mode_sel = 0; step();
    chk("drain_from_auto", 14'(mode_busy), 14'(1));
    wait_sig(0, 0, "drain_exit");
    chk("manual_cmd", 14'({next_state, next_moving_state}), 14'({MOVE, BACK}));
    mode_sel = 1; step();
    wait_sig(1, 1, "auto_reentry");
    chk("cnt_clear", 14'(beacon_cnt), 14'(0));

    // Saturation at MAX_BEACONS.
    n_pulses = 0;
    for (int k = 0; k < 5; k++) begin
      auto_pl_beacon = 1; step(); auto_pl_beacon = 0; repeat (9) step();
    end
    chk("sat_pulses", 14'(n_pulses), 14'(3));
    chk("sat_cnt", 14'(beacon_cnt), 14'(3));

    // Destination edge wins over mode_sel falling in the same cycle.
    auto_de_beacon = 1; mode_sel = 0; step();
    chk("dest_done", w_obs, pk(WAIT, FRONT, 0, 0, 3, 1, 0));
    step();
    chk("dest_drain", w_obs, pk(WAIT, FRONT, 0, 0, 3, 0, 1));
    auto_de_beacon = 0; step(); step();

    // Power loss mid-DRAIN, power back into AUTO, then reset mid-AUTO.
    power = 0; step();
    chk("pwr_off", w_obs, pk(WAIT, FRONT, 0, 0, 3, 0, 0));
    step();
    power = 1; mode_sel = 1; step();
    chk("pwr_idle", w_obs, pk(WAIT, FRONT, 0, 0, 3, 0, 0));
    step();
    chk("pwr_auto", w_obs, pk(TURN, LEFT, 1, 0, 0, 0, 0));
    auto_pl_beacon = 1; step();
    chk("pwr_place", w_obs, pk(TURN, LEFT, 1, 1, 1, 0, 0));
    auto_pl_beacon = 0; rst = 1; step();
    chk("rst_mid_auto", w_obs, pk(WAIT, FRONT, 0, 0, 0, 0, 0));

    // Randomized run against the behavioural model.
    model_step();
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(399) == 0);
      if (power) power = ($urandom_range(299) != 0);
      else       power = ($urandom_range(3) == 0);
      if ($urandom_range(29) == 0) mode_sel = ~mode_sel;
      if ($urandom_range(2) == 0)  auto_pl_beacon = ~auto_pl_beacon;
      if ($urandom_range(24) == 0) auto_de_beacon = ~auto_de_beacon;
      man_state  = 2'($urandom); man_move  = 4'($urandom);
      auto_state = 2'($urandom); auto_move = 4'($urandom);
      model_step();
      step();
      chk($sformatf("rand%0d", c), w_obs, m_exp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
